execute_stage_p: RTL and testbench
==================================

// Module: execute_stage_p
// PURPOSE
//  Parametrised EX stage plus EX/MEM pipeline register for the 5-stage RISC-V core.
//  - Covers the full RV32I ALU, branch-condition evaluation and operand forwarding.
//  - Computes the branch/jump target and PCSrcE.
//  - Optional iterative multiplier stalls the pipe via BusyE.
//  - Sits between the ID/EX register and the memory stage.
// PARAMETERS
//  XLEN      32  datapath width; power of two >= 8
//  REG_AW     5  register-address width
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high
//  RD1E,RD2E    in   XLEN  register operands
//  ImmExtE      in   XLEN  extended immediate
//  PCE,PCPlus4E in   XLEN  PC and PC+4 of the EX instruction
//  RdE          in   REG_AW destination register
//  RegWriteE,MemWriteE,JumpE,JalrE,BranchE,ALUSrcE  in 1  decoded controls
//  ResultSrcE   in   2     writeback select
//  ALUControlE  in   4     ALU op, see BEHAVIOUR
//  BranchTypeE  in   3     funct3 of the branch
//  ForwardAE,ForwardBE in 2  00 RDxE, 01 ResultW, 10 ALUResultM
//  ResultW      in   XLEN  writeback value
//  FlushE       in   1     kill the EX instruction; aborts a multiply
//  PCTargetE    out  XLEN  branch/jump target (combinational)
//  PCSrcE       out  1     redirect fetch (combinational)
//  BusyE        out  1     hold F/D/E; combinational
//  ALUResultM,WriteDataM,PCPlus4M  out XLEN  registered
//  RdM          out  REG_AW registered
//  RegWriteM,MemWriteM  out 1  registered
//  ResultSrcM   out  2     registered
// BEHAVIOUR
//  - Reset: every registered output = 0; multiplier FSM enters IDLE.
//  - SrcA = fwd(RD1E,ForwardAE). FwdB = fwd(RD2E,ForwardBE).
//  - SrcB = ALUSrcE ? ImmExtE : FwdB. WriteData = FwdB. Forward code 11 selects RDxE.
//  - ALU ops, results mod 2^XLEN:
//    0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL,
//    8 SRL, 9 SRA (shamt = SrcB[$clog2(XLEN)-1:0]), A pass SrcB, B MUL; others -> 0.
//  - Branch condition on SrcA/FwdB, by BranchTypeE:
//    000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
//  - PCSrcE = (BranchE & cond | JumpE) & ~BusyE & ~FlushE.
//  - PCTargetE = JalrE ? (SrcA+ImmExtE) & ~1 : PCE+ImmExtE.
//  - EX/MEM register loads every cycle.
//    If BusyE | FlushE it loads a bubble: all fields 0.
//    Otherwise it loads the EX values. Single-op latency: result in M 1 cycle after E.
//  - Multiplier FSM IDLE/BUSY/DONE:
//    IDLE: on op B & ~FlushE, latch SrcA/SrcB, cnt = XLEN, go BUSY; BusyE=1 this cycle.
//    BUSY: one shift-add step per cycle, cnt--, BusyE=1; cnt reaches 0 -> DONE.
//    DONE: BusyE=0, ALU output = low XLEN product bits; captured; -> IDLE.
//    A back-to-back MUL restarts from IDLE on the next cycle.
//    MUL occupies E for XLEN+2 cycles; BusyE high for XLEN+1.
//    FlushE in any state -> IDLE next cycle, BusyE=0, bubble into M.
//    Operands are latched at start, so forwarding changes during BUSY are ignored.
//  - Asserting reset mid-multiply clears the FSM and the EX/MEM register immediately.
// CONFIGURATION
//  - EXEC_MUL_EN defined: FSM and multiplier present.
//  - Undefined: op B yields 0, BusyE tied 0, no FSM state; all else identical.
// TESTING
//  1. ADD, RD1E=5, RD2E=7, fwd 00 -> next cycle ALUResultM=12, RegWriteM=1.
//  2. SRA, SrcA=0x80000000, SrcB=4 -> ALUResultM=0xF8000000.
//     SLT(-1,1)=1; SLTU(-1,1)=0.
//  3. BranchE, BLT, SrcA=-3, FwdB=2, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120.
//     BGEU with the same operands -> PCSrcE=1.
//  4. JalrE, SrcA=0x203, Imm=4 -> PCTargetE=0x206.
//     ForwardAE=10 with ALUResultM=9 -> SrcA=9.
//  5. EXEC_MUL_EN: MUL 6*7 -> BusyE high 33 cycles, M bubbles meanwhile, then ALUResultM=42.
//     MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
//  6. FlushE in the 10th BUSY cycle -> BusyE=0 next cycle, RegWriteM=0, FSM IDLE.
//     Reset mid-BUSY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/execute_stage_p.sv
// execute_stage_p: execute stage of the 5-stage RISC-V core with its EX/MEM
// pipeline register. Implements the RV32I ALU, operand forwarding, branch
// condition evaluation, branch/jump target generation and fetch redirect.
// Optional feature macro: EXEC_MUL_EN. When defined, ALU op 4'hB is a
// multi-cycle shift-add multiplier that stalls the front of the pipe through
// BusyE. When undefined, op 4'hB yields zero and BusyE is tied low.
module execute_stage_p #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   RD1E,
    input  logic [XLEN-1:0]   RD2E,
    input  logic [XLEN-1:0]   ImmExtE,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              JumpE,
    input  logic              JalrE,
    input  logic              BranchE,
    input  logic              ALUSrcE,
    input  logic [1:0]        ResultSrcE,
    input  logic [3:0]        ALUControlE,
    input  logic [2:0]        BranchTypeE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              FlushE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              PCSrcE,
    output logic              BusyE,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [REG_AW-1:0] RdM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM
);

    localparam int SHW   = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;

    // ALU operation encodings
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SLT   = 4'h5;
    localparam logic [3:0] OP_SLTU  = 4'h6;
    localparam logic [3:0] OP_SLL   = 4'h7;
    localparam logic [3:0] OP_SRL   = 4'h8;
    localparam logic [3:0] OP_SRA   = 4'h9;
    localparam logic [3:0] OP_PASSB = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;

    // Forwarding select codes; 2'b11 falls back to the register file value
    localparam logic [1:0] FWD_RESW = 2'b01;
    localparam logic [1:0] FWD_ALUM = 2'b10;

    // JALR targets always have bit 0 cleared
    localparam logic [XLEN-1:0] LSB_CLR = ~{{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] src_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] src_b_s;
    logic [SHW-1:0]  shamt_s;
    logic [XLEN-1:0] alu_result_s;
    logic [XLEN-1:0] mul_result_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic            eq_s;
    logic            lt_s;
    logic            ltu_s;
    logic            branch_cond_s;
    logic            busy_s;

    assign shamt_s = src_b_s[SHW-1:0];

    // Operand forwarding for SrcA / FwdB and the immediate select for SrcB
    always_comb begin
        case (ForwardAE)
            FWD_RESW: src_a_s = ResultW;
            FWD_ALUM: src_a_s = ALUResultM;
            default:  src_a_s = RD1E;
        endcase
        case (ForwardBE)
            FWD_RESW: fwd_b_s = ResultW;
            FWD_ALUM: fwd_b_s = ALUResultM;
            default:  fwd_b_s = RD2E;
        endcase
        if (ALUSrcE) begin
            src_b_s = ImmExtE;
        end else begin
            src_b_s = fwd_b_s;
        end
    end

    // Main ALU; unused opcodes produce zero
    always_comb begin
        alu_result_s = {XLEN{1'b0}};
        case (ALUControlE)
            OP_ADD:   alu_result_s = src_a_s + src_b_s;
            OP_SUB:   alu_result_s = src_a_s - src_b_s;
            OP_AND:   alu_result_s = src_a_s & src_b_s;
            OP_OR:    alu_result_s = src_a_s | src_b_s;
            OP_XOR:   alu_result_s = src_a_s ^ src_b_s;
            OP_SLT:   alu_result_s = {{(XLEN-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
            OP_SLTU:  alu_result_s = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
            OP_SLL:   alu_result_s = src_a_s << shamt_s;
            OP_SRL:   alu_result_s = src_a_s >> shamt_s;
            OP_SRA:   alu_result_s = $unsigned($signed(src_a_s) >>> shamt_s);
            OP_PASSB: alu_result_s = src_b_s;
            OP_MUL:   alu_result_s = mul_result_s;
            default:  alu_result_s = {XLEN{1'b0}};
        endcase
    end

    // Branch condition compares SrcA against FwdB, never against the immediate
    always_comb begin
        eq_s  = (src_a_s == fwd_b_s);
        lt_s  = ($signed(src_a_s) < $signed(fwd_b_s));
        ltu_s = (src_a_s < fwd_b_s);
        case (BranchTypeE)
            3'b000:  branch_cond_s = eq_s;
            3'b001:  branch_cond_s = ~eq_s;
            3'b100:  branch_cond_s = lt_s;
            3'b101:  branch_cond_s = ~lt_s;
            3'b110:  branch_cond_s = ltu_s;
            3'b111:  branch_cond_s = ~ltu_s;
            default: branch_cond_s = 1'b0;
        endcase
    end

    // Branch/jump target: register-relative for JALR, PC-relative otherwise
    always_comb begin
        jalr_sum_s = src_a_s + ImmExtE;
        if (JalrE) begin
            PCTargetE = jalr_sum_s & LSB_CLR;
        end else begin
            PCTargetE = PCE + ImmExtE;
        end
    end

    // Fetch redirect is suppressed while stalled or when this slot is killed
    always_comb begin
        PCSrcE = ((BranchE & branch_cond_s) | JumpE) & ~BusyE & ~FlushE;
    end

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    mul_state_t      state_r;
    mul_state_t      state_nxt_s;
    logic [XLEN-1:0] mcand_r;
    logic [XLEN-1:0] mplier_r;
    logic [XLEN-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic            start_s;
    logic            step_s;

    // Multiplier state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= MUL_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Multiplier next state, stall request and datapath strobes
    always_comb begin
        state_nxt_s = state_r;
        busy_s      = 1'b0;
        start_s     = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            MUL_IDLE: begin
                if ((ALUControlE == OP_MUL) && !FlushE) begin
                    start_s     = 1'b1;
                    busy_s      = 1'b1;
                    state_nxt_s = MUL_BUSY;
                end else begin
                    state_nxt_s = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                if (FlushE) begin
                    state_nxt_s = MUL_IDLE;
                end else begin
                    busy_s = 1'b1;
                    step_s = 1'b1;
                    if (cnt_r == CNT_W'(1)) begin
                        state_nxt_s = MUL_DONE;
                    end else begin
                        state_nxt_s = MUL_BUSY;
                    end
                end
            end
            MUL_DONE: begin
                state_nxt_s = MUL_IDLE;
            end
            default: begin
                state_nxt_s = MUL_IDLE;
            end
        endcase
    end

    // Shift-add datapath: operands latched at start, one partial product per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r  <= {XLEN{1'b0}};
            mplier_r <= {XLEN{1'b0}};
            acc_r    <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (start_s) begin
            mcand_r  <= src_a_s;
            mplier_r <= src_b_s;
            acc_r    <= {XLEN{1'b0}};
            cnt_r    <= CNT_W'(XLEN);
        end else if (step_s) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r - CNT_W'(1);
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
            cnt_r    <= cnt_r;
        end
    end

    // Product is only presented to the ALU mux in the DONE cycle
    always_comb begin
        if (state_r == MUL_DONE) begin
            mul_result_s = acc_r;
        end else begin
            mul_result_s = {XLEN{1'b0}};
        end
    end
`else
    // Multiplier absent: op B yields zero and the pipe never stalls
    always_comb begin
        mul_result_s = {XLEN{1'b0}};
        busy_s       = 1'b0;
    end
`endif

    // Stall output; held low while reset is asserted so outputs clear at once
    always_comb begin
        BusyE = busy_s & ~reset;
    end

    // EX/MEM pipeline register; stalls and flushes insert an all-zero bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUResultM <= {XLEN{1'b0}};
            WriteDataM <= {XLEN{1'b0}};
            PCPlus4M   <= {XLEN{1'b0}};
            RdM        <= {REG_AW{1'b0}};
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
        end else if (BusyE || FlushE) begin
            ALUResultM <= {XLEN{1'b0}};
            WriteDataM <= {XLEN{1'b0}};
            PCPlus4M   <= {XLEN{1'b0}};
            RdM        <= {REG_AW{1'b0}};
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
        end else begin
            ALUResultM <= alu_result_s;
            WriteDataM <= fwd_b_s;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
        end
    end

endmodule

// File: tb/tb_execute_stage_p.sv
// tb_execute_stage_p: self-checking bench for execute_stage_p (XLEN=32).
// Directed cases plus randomized traffic checked against an arithmetic
// reference model. Multiplier scenarios are selected by EXEC_MUL_EN.
module tb_execute_stage_p;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [REG_AW-1:0] RdE;
    logic              RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, FlushE;
    logic [1:0]        ResultSrcE, ForwardAE, ForwardBE;
    logic [3:0]        ALUControlE;
    logic [2:0]        BranchTypeE;
    logic [XLEN-1:0]   PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic              PCSrcE, BusyE, RegWriteM, MemWriteM;
    logic [REG_AW-1:0] RdM;
    logic [1:0]        ResultSrcM;

    int cmp_count  = 0;
    int fail_count = 0;
    logic [XLEN-1:0] model_alu_m;

    execute_stage_p #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .JalrE(JalrE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .BranchTypeE(BranchTypeE), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ResultW(ResultW), .FlushE(FlushE),
        .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .BusyE(BusyE),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
    );

    always #5 clk = ~clk;

    // Reference: operand selected by a forwarding code
    function automatic logic [31:0] ref_fwd(input logic [1:0] code, input logic [31:0] rd,
                                            input logic [31:0] resw, input logic [31:0] alum);
        if (code == 2'b01) return resw;
        if (code == 2'b10) return alum;
        return rd;
    endfunction

    // Reference: ALU result from plain arithmetic
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        logic [31:0] ones;
        logic [31:0] fill;
        sh   = int'(b % 32);
        ones = 32'hFFFF_FFFF;
        fill = a[31] ? ~(ones >> sh) : 32'h0;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h6: return (a < b) ? 32'd1 : 32'd0;
            4'h7: return a << sh;
            4'h8: return a >> sh;
            4'h9: return (a >> sh) | fill;
            4'hA: return b;
            4'hB: return MUL_EN ? a * b : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // Reference: branch condition
    function automatic logic ref_cond(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
        case (bt)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 4));
            1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            2: return 32'h8000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic drive_idle();
        RD1E = 32'h0; RD2E = 32'h0; ImmExtE = 32'h0; PCE = 32'h0; PCPlus4E = 32'h0;
        ResultW = 32'h0; RdE = 5'd0; RegWriteE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0;
        JalrE = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b0; FlushE = 1'b0; ResultSrcE = 2'b00;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ALUControlE = 4'h0; BranchTypeE = 3'b000;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        RD1E = 32'h5; RD2E = 32'h9; RegWriteE = 1'b1; MemWriteE = 1'b1; RdE = 5'd3;
        PCPlus4E = 32'h4; ResultSrcE = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        cmp_count++;
        if (ALUResultM !== 32'h0 || WriteDataM !== 32'h0 || PCPlus4M !== 32'h0 || RdM !== 5'd0 ||
            RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || ResultSrcM !== 2'b00 || BusyE !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_state: got alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%b busy=%b, expected all 0",
                     ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM, BusyE);
        end
        #2 reset = 1'b0;
        drive_idle();
        @(posedge clk); #1;
        model_alu_m = 32'h0;
    endtask

    task automatic test_alu_directed();
        logic [3:0]  ops [5] = '{4'h0, 4'h9, 4'h5, 4'h6, 4'hA};
        logic [31:0] as  [5] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] bs  [5] = '{32'd7, 32'd4, 32'd1, 32'd1, 32'h1234_5678};
        logic [31:0] exps[5] = '{32'd12, 32'hF800_0000, 32'd1, 32'd0, 32'h1234_5678};
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            RD1E = as[i]; RD2E = bs[i]; ALUControlE = ops[i]; RegWriteE = 1'b1; RdE = 5'(i + 1);
            @(posedge clk); #1;
            cmp_count++;
            if (ALUResultM !== exps[i] || RegWriteM !== 1'b1 || RdM !== 5'(i + 1)) begin
                fail_count++;
                $display("FAIL alu_directed[%0d]: got alu=%h rw=%b rd=%0d, expected alu=%h rw=1 rd=%0d",
                         i, ALUResultM, RegWriteM, RdM, exps[i], i + 1);
            end
            model_alu_m = exps[i];
        end
    endtask

    task automatic test_branch_jump();
        // BLT taken with signed operands
        drive_idle();
        RD1E = 32'hFFFF_FFFD; RD2E = 32'd2; PCE = 32'h100; ImmExtE = 32'h20;
        BranchE = 1'b1; BranchTypeE = 3'b100;
        #1;
        cmp_count++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
            fail_count++;
            $display("FAIL branch_blt: got pcsrc=%b tgt=%h, expected pcsrc=1 tgt=00000120", PCSrcE, PCTargetE);
        end
        BranchTypeE = 3'b111;
        #1;
        cmp_count++;
        if (PCSrcE !== 1'b1) begin
            fail_count++;
            $display("FAIL branch_bgeu: got pcsrc=%b, expected 1", PCSrcE);
        end
        BranchTypeE = 3'b010;
        #1;
        cmp_count++;
        if (PCSrcE !== 1'b0) begin
            fail_count++;
            $display("FAIL branch_never: got pcsrc=%b, expected 0", PCSrcE);
        end
        // JALR target clears bit 0
        drive_idle();
        RD1E = 32'h203; ImmExtE = 32'h4; JumpE = 1'b1; JalrE = 1'b1; PCE = 32'h500;
        #1;
        cmp_count++;
        if (PCTargetE !== 32'h206 || PCSrcE !== 1'b1) begin
            fail_count++;
            $display("FAIL jalr_target: got tgt=%h pcsrc=%b, expected tgt=00000206 pcsrc=1", PCTargetE, PCSrcE);
        end
        // Forward ALUResultM into SrcA
        drive_idle();
        RD1E = 32'd4; RD2E = 32'd5;
        @(posedge clk); #1;
        cmp_count++;
        if (ALUResultM !== 32'd9) begin
            fail_count++;
            $display("FAIL fwd_setup: got alu=%h, expected 00000009", ALUResultM);
        end
        drive_idle();
        RD1E = 32'h777; ForwardAE = 2'b10; ALUSrcE = 1'b1; ImmExtE = 32'h10;
        JumpE = 1'b1; JalrE = 1'b1;
        #1;
        cmp_count++;
        if (PCTargetE !== 32'h18) begin
            fail_count++;
            $display("FAIL fwd_alum_target: got tgt=%h, expected 00000018", PCTargetE);
        end
        @(posedge clk); #1;
        cmp_count++;
        if (ALUResultM !== 32'h19) begin
            fail_count++;
            $display("FAIL fwd_alum_result: got alu=%h, expected 00000019", ALUResultM);
        end
        drive_idle();
        @(posedge clk); #1;
        model_alu_m = 32'h0;
    endtask

    task automatic test_random();
        logic [31:0] a, fb, b, exp_alu, exp_tgt;
        logic        exp_pcsrc;
        for (int i = 0; i < 80; i++) begin
            drive_idle();
            ALUControlE = 4'($urandom_range(0, 15));
            if (MUL_EN && ALUControlE == 4'hB) ALUControlE = 4'h0;
            RD1E = rand_val(); RD2E = rand_val(); ImmExtE = rand_val(); ResultW = rand_val();
            PCE = 32'($urandom); PCPlus4E = 32'($urandom); RdE = 5'($urandom_range(0, 31));
            RegWriteE = 1'($urandom_range(0, 1)); MemWriteE = 1'($urandom_range(0, 1));
            JumpE = ($urandom_range(0, 3) == 0); JalrE = 1'($urandom_range(0, 1));
            BranchE = 1'($urandom_range(0, 1)); ALUSrcE = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3)); BranchTypeE = 3'($urandom_range(0, 7));
            ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
            FlushE = ($urandom_range(0, 5) == 0);
            a  = ref_fwd(ForwardAE, RD1E, ResultW, model_alu_m);
            fb = ref_fwd(ForwardBE, RD2E, ResultW, model_alu_m);
            b  = ALUSrcE ? ImmExtE : fb;
            exp_alu   = ref_alu(ALUControlE, a, b);
            exp_tgt   = JalrE ? ((a + ImmExtE) & 32'hFFFF_FFFE) : (PCE + ImmExtE);
            exp_pcsrc = ((BranchE && ref_cond(BranchTypeE, a, fb)) || JumpE) && !FlushE;
            #1;
            cmp_count++;
            if (PCSrcE !== exp_pcsrc || PCTargetE !== exp_tgt || BusyE !== 1'b0) begin
                fail_count++;
                $display("FAIL rand_ex[%0d]: got pcsrc=%b tgt=%h busy=%b, expected pcsrc=%b tgt=%h busy=0",
                         i, PCSrcE, PCTargetE, BusyE, exp_pcsrc, exp_tgt);
            end
            @(posedge clk); #1;
            if (FlushE) begin
                cmp_count++;
                if (ALUResultM !== 32'h0 || WriteDataM !== 32'h0 || PCPlus4M !== 32'h0 || RdM !== 5'd0 ||
                    RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || ResultSrcM !== 2'b00) begin
                    fail_count++;
                    $display("FAIL rand_flush[%0d]: got alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%b, expected bubble",
                             i, ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM);
                end
                model_alu_m = 32'h0;
            end else begin
                cmp_count++;
                if (ALUResultM !== exp_alu || WriteDataM !== fb || PCPlus4M !== PCPlus4E || RdM !== RdE ||
                    RegWriteM !== RegWriteE || MemWriteM !== MemWriteE || ResultSrcM !== ResultSrcE) begin
                    fail_count++;
                    $display("FAIL rand_m[%0d] op=%h: got alu=%h wd=%h pc4=%h rd=%0d, expected alu=%h wd=%h pc4=%h rd=%0d",
                             i, ALUControlE, ALUResultM, WriteDataM, PCPlus4M, RdM, exp_alu, fb, PCPlus4E, RdE);
                end
                model_alu_m = exp_alu;
            end
        end
        drive_idle();
        @(posedge clk); #1;
        model_alu_m = 32'h0;
    endtask

`ifdef EXEC_MUL_EN
    task automatic test_mul();
        logic [31:0] ma [2] = '{32'd6, 32'hFFFF_FFFF};
        logic [31:0] mb [2] = '{32'd7, 32'd2};
        logic [31:0] expv;
        int n;
        for (int k = 0; k < 2; k++) begin
            drive_idle();
            RD1E = ma[k]; RD2E = mb[k]; ALUControlE = 4'hB; RegWriteE = 1'b1; RdE = 5'(7 + k);
            JumpE = (k == 0); PCE = 32'h40; ImmExtE = 32'h8; PCPlus4E = 32'h44;
            expv = ma[k] * mb[k];
            #1;
            cmp_count++;
            if (BusyE !== 1'b1) begin
                fail_count++;
                $display("FAIL mul_start_busy[%0d]: got %b, expected 1", k, BusyE);
            end
            n = 0;
            while (BusyE === 1'b1 && n < 100) begin
                n++;
                cmp_count++;
                if (PCSrcE !== 1'b0) begin
                    fail_count++;
                    $display("FAIL mul_pcsrc_stall[%0d]: got %b, expected 0", k, PCSrcE);
                end
                @(posedge clk); #1;
                if (n == 1) begin
                    ForwardAE = 2'b01; ResultW = 32'h0;
                    #1;
                end
                cmp_count++;
                if (RegWriteM !== 1'b0 || ALUResultM !== 32'h0) begin
                    fail_count++;
                    $display("FAIL mul_bubble[%0d]: got rw=%b alu=%h, expected rw=0 alu=0", k, RegWriteM, ALUResultM);
                end
            end
            cmp_count++;
            if (n !== 33) begin
                fail_count++;
                $display("FAIL mul_busy_cycles[%0d]: got %0d, expected 33", k, n);
            end
            cmp_count++;
            if (PCSrcE !== (k == 0)) begin
                fail_count++;
                $display("FAIL mul_done_pcsrc[%0d]: got %b, expected %b", k, PCSrcE, (k == 0));
            end
            @(posedge clk); #1;
            cmp_count++;
            if (ALUResultM !== expv || RegWriteM !== 1'b1 || RdM !== 5'(7 + k) ||
                WriteDataM !== mb[k] || PCPlus4M !== 32'h44) begin
                fail_count++;
                $display("FAIL mul_result[%0d]: got alu=%h rw=%b rd=%0d wd=%h pc4=%h, expected alu=%h rw=1 rd=%0d wd=%h pc4=00000044",
                         k, ALUResultM, RegWriteM, RdM, WriteDataM, PCPlus4M, expv, 7 + k, mb[k]);
            end
            model_alu_m = expv;
        end
        drive_idle();
        @(posedge clk); #1;
        model_alu_m = 32'h0;
    endtask

    task automatic test_mul_flush();
        drive_idle();
        RD1E = 32'd3; RD2E = 32'd5; ALUControlE = 4'hB; RegWriteE = 1'b1; RdE = 5'd2;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        cmp_count++;
        if (BusyE !== 1'b1) begin
            fail_count++;
            $display("FAIL mul_busy10: got %b, expected 1", BusyE);
        end
        FlushE = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        RD1E = 32'd1; RD2E = 32'd2; RegWriteE = 1'b1; RdE = 5'd4;
        #1;
        cmp_count++;
        if (BusyE !== 1'b0 || RegWriteM !== 1'b0 || ALUResultM !== 32'h0) begin
            fail_count++;
            $display("FAIL mul_flush: got busy=%b rw=%b alu=%h, expected busy=0 rw=0 alu=0", BusyE, RegWriteM, ALUResultM);
        end
        @(posedge clk); #1;
        cmp_count++;
        if (ALUResultM !== 32'd3 || RegWriteM !== 1'b1 || BusyE !== 1'b0) begin
            fail_count++;
            $display("FAIL mul_flush_idle: got alu=%h rw=%b busy=%b, expected alu=3 rw=1 busy=0", ALUResultM, RegWriteM, BusyE);
        end
        drive_idle();
        @(posedge clk); #1;
        model_alu_m = 32'h0;
    endtask

    task automatic test_mul_reset();
        drive_idle();
        RD1E = 32'd9; RD2E = 32'd9; ALUControlE = 4'hB; RegWriteE = 1'b1; RdE = 5'd6;
        repeat (6) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        cmp_count++;
        if (BusyE !== 1'b0 || ALUResultM !== 32'h0 || RegWriteM !== 1'b0 || RdM !== 5'd0 || PCPlus4M !== 32'h0) begin
            fail_count++;
            $display("FAIL mul_reset_async: got busy=%b alu=%h rw=%b rd=%0d pc4=%h, expected all 0",
                     BusyE, ALUResultM, RegWriteM, RdM, PCPlus4M);
        end
        ALUControlE = 4'h0; RD1E = 32'd10; RD2E = 32'd20;
        #1 reset = 1'b0;
        #1;
        cmp_count++;
        if (BusyE !== 1'b0) begin
            fail_count++;
            $display("FAIL mul_reset_idle: got busy=%b, expected 0", BusyE);
        end
        @(posedge clk); #1;
        cmp_count++;
        if (ALUResultM !== 32'd30 || RegWriteM !== 1'b1) begin
            fail_count++;
            $display("FAIL mul_reset_after: got alu=%h rw=%b, expected alu=0000001e rw=1", ALUResultM, RegWriteM);
        end
        drive_idle();
        @(posedge clk); #1;
        model_alu_m = 32'h0;
    endtask
`else
    task automatic test_mul_disabled();
        drive_idle();
        RD1E = 32'd6; RD2E = 32'd7; ALUControlE = 4'hB; RegWriteE = 1'b1; RdE = 5'd5;
        #1;
        cmp_count++;
        if (BusyE !== 1'b0) begin
            fail_count++;
            $display("FAIL nomul_busy: got %b, expected 0", BusyE);
        end
        @(posedge clk); #1;
        cmp_count++;
        if (ALUResultM !== 32'h0 || RegWriteM !== 1'b1 || RdM !== 5'd5) begin
            fail_count++;
            $display("FAIL nomul_result: got alu=%h rw=%b rd=%0d, expected alu=0 rw=1 rd=5", ALUResultM, RegWriteM, RdM);
        end
        drive_idle();
        @(posedge clk); #1;
        model_alu_m = 32'h0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_alu_m = 32'h0;
        test_reset();
        test_alu_directed();
        test_branch_jump();
        test_random();
`ifdef EXEC_MUL_EN
        test_mul();
        test_mul_flush();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
